// File: rtl/wasm_i2c_pkg.sv
// Shared definitions for the WASM I2C debug target.
//   i2c_state_e      : protocol FSM states
//   DEFAULT_DEV_ADDR : 7-bit device address the target answers to by default
//   SDA_ACK/SDA_NACK : SDA levels for acknowledge / not-acknowledge
package wasm_i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_REG,
        ST_REG_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RDATA_ACK,
        ST_IGNORE
    } i2c_state_e;

    localparam logic [6:0] DEFAULT_DEV_ADDR = 7'h6C;
    localparam logic       SDA_ACK          = 1'b0;
    localparam logic       SDA_NACK         = 1'b1;

endpackage

// File: rtl/i2c_bus_sync.sv
// Brings the asynchronous SCL/SDA pins into the clk domain and derives
// single-cycle bus events from them.
//   clk, rst_n : core clock, asynchronous active-low reset
//   i_scl      : SCL pin (asynchronous)
//   i_sda      : SDA pin as seen on the wire (asynchronous)
//   sda        : synchronized SDA, aligned with the event pulses below
//   scl_rise   : one-cycle pulse, SCL went high
//   scl_fall   : one-cycle pulse, SCL went low
//   start      : one-cycle pulse, SDA fell while SCL high
//   stop       : one-cycle pulse, SDA rose while SCL high
// Every output is registered, so a pin edge is visible SYNC_STAGES+1 clk later.
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_scl,
    input  logic i_sda,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [SYNC_STAGES-1:0] scl_sync;
    logic [SYNC_STAGES-1:0] sda_sync;
    logic                   scl_now;
    logic                   sda_now;
    logic                   scl_q;
    logic                   sda_q;

    assign scl_now = scl_sync[SYNC_STAGES-1];
    assign sda_now = sda_sync[SYNC_STAGES-1];
    assign sda     = sda_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the synchronizer resets to the idle-bus level (both lines
            // high) so releasing reset can never fabricate a START or STOP.
            scl_sync <= '1;
            sda_sync <= '1;
            scl_q    <= 1'b1;
            sda_q    <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every flop sample the old
            // value of its neighbour, which is what makes this a shift chain.
            scl_sync <= {scl_sync[SYNC_STAGES-2:0], i_scl};
            sda_sync <= {sda_sync[SYNC_STAGES-2:0], i_sda};
            scl_q    <= scl_now;
            sda_q    <= sda_now;
            scl_rise <= scl_now & ~scl_q;
            scl_fall <= ~scl_now & scl_q;
            start    <= scl_now & scl_q & sda_q & ~sda_now;
            stop     <= scl_now & scl_q & ~sda_q & sda_now;
        end
    end

endmodule

// File: rtl/wasm_i2c_dbg_slave.sv
// I2C target exposing the WASM debug register space.
//   DEV_ADDR, SYNC_STAGES        : device address, synchronizer depth
//   clk, rst_n                   : core clock, asynchronous active-low reset
//   i_scl, i_sda, o_sda          : bus pins (o_sda: 0 = pull low, 1 = release)
//   i_enable                     : 0 hides the target from the bus
//   o_reg_rd_req/o_reg_rd_addr   : one-cycle read strobe and address
//   i_reg_rd_data                : read data, valid 1 clk after the strobe
//   o_reg_wr_vld/addr/data       : one-cycle write strobe, address, data
//   o_busy                       : addressed, until STOP or a foreign address
// Frame: START, addr+R/W, ACK, then either a register pointer byte followed by
// write bytes (each ACKed, pointer++), or read bytes driven from the pointer.
module wasm_i2c_dbg_slave
    import wasm_i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = DEFAULT_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_scl,
    input  logic       i_sda,
    output logic       o_sda,
    input  logic       i_enable,
    output logic       o_reg_rd_req,
    output logic [7:0] o_reg_rd_addr,
    input  logic [7:0] i_reg_rd_data,
    output logic       o_reg_wr_vld,
    output logic [7:0] o_reg_wr_addr,
    output logic [7:0] o_reg_wr_data,
    output logic       o_busy
);

    logic sda, scl_rise, scl_fall, start, stop;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_scl    (i_scl),
        .i_sda    (i_sda),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    i2c_state_e state_q, state_d;
    logic [3:0] bit_cnt_q, bit_cnt_d;   // bits of the current byte seen so far
    logic [7:0] rx_q, rx_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] ptr_q, ptr_d;
    logic       sda_out_q, sda_out_d;
    logic       ninth_q, ninth_d;       // ninth SCL rise of the ACK slot seen
    logic       busy_q, busy_d;
    logic       rd_req_q, rd_req_d;
    logic [7:0] rd_addr_q, rd_addr_d;
    logic       wr_vld_q, wr_vld_d;
    logic [7:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       rd_pending_q;           // read data arrives this cycle

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       ack_done;

    assign rx_byte   = {rx_q[6:0], sda};
    assign byte_done = scl_rise && (bit_cnt_q == 4'd7);
    assign ack_done  = scl_fall && ninth_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            rx_q         <= '0;
            tx_q         <= '0;
            ptr_q        <= '0;
            sda_out_q    <= 1'b1;
            ninth_q      <= 1'b0;
            busy_q       <= 1'b0;
            rd_req_q     <= 1'b0;
            rd_addr_q    <= '0;
            wr_vld_q     <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            rd_pending_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            rx_q         <= rx_d;
            tx_q         <= tx_d;
            ptr_q        <= ptr_d;
            sda_out_q    <= sda_out_d;
            ninth_q      <= ninth_d;
            busy_q       <= busy_d;
            rd_req_q     <= rd_req_d;
            rd_addr_q    <= rd_addr_d;
            wr_vld_q     <= wr_vld_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            rd_pending_q <= rd_req_q;
        end
    end

    always_comb begin
        // NOTE: every signal gets a hold/idle default before any branch, so no
        // path through this block leaves a value unassigned (no latches).
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        sda_out_d = sda_out_q;
        ninth_d   = ninth_q;
        busy_d    = busy_q;
        rd_req_d  = 1'b0;
        rd_addr_d = rd_addr_q;
        wr_vld_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;

        // Prefetched byte lands in the TX shifter long before the SCL fall
        // that starts driving it.
        if (rd_pending_q) begin
            tx_d = i_reg_rd_data;
        end

        if (!i_enable || stop) begin
            state_d   = ST_IDLE;
            sda_out_d = SDA_NACK;
            bit_cnt_d = '0;
            ninth_d   = 1'b0;
            busy_d    = 1'b0;
        end else if (start) begin
            state_d   = ST_ADDR;
            sda_out_d = SDA_NACK;
            bit_cnt_d = '0;
            ninth_d   = 1'b0;
        end else begin
            // Receiving states share the MSB-first shifter.
            if (scl_rise && (state_q inside {ST_ADDR, ST_REG, ST_WDATA})) begin
                rx_d      = rx_byte;
                bit_cnt_d = bit_cnt_q + 4'd1;
            end

            // Target-ACK slots: pull low from the fall after bit 8 until the
            // fall after bit 9.
            if (state_q inside {ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK}) begin
                if (scl_rise) begin
                    ninth_d = 1'b1;
                end
                if (scl_fall) begin
                    if (!ninth_q) begin
                        sda_out_d = SDA_ACK;
                    end else begin
                        sda_out_d = SDA_NACK;
                        ninth_d   = 1'b0;
                        bit_cnt_d = '0;
                    end
                end
            end

            case (state_q)
                ST_ADDR: begin
                    if (byte_done) begin
                        if (rx_byte[7:1] == DEV_ADDR) begin
                            state_d = ST_ADDR_ACK;
                            busy_d  = 1'b1;
                            if (rx_byte[0]) begin
                                rd_req_d  = 1'b1;
                                rd_addr_d = ptr_q;
                            end
                        end else begin
                            state_d = ST_IGNORE;
                            busy_d  = 1'b0;
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (ack_done) begin
                        if (rx_q[0]) begin
                            state_d   = ST_RDATA;
                            sda_out_d = tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                        end else begin
                            state_d = ST_REG;
                        end
                    end
                end
                ST_REG: begin
                    if (byte_done) begin
                        ptr_d   = rx_byte;
                        state_d = ST_REG_ACK;
                    end
                end
                ST_REG_ACK: begin
                    if (ack_done) begin
                        state_d = ST_WDATA;
                    end
                end
                ST_WDATA: begin
                    if (byte_done) begin
                        wr_vld_d  = 1'b1;
                        wr_addr_d = ptr_q;
                        wr_data_d = rx_byte;
                        state_d   = ST_WDATA_ACK;
                    end
                end
                ST_WDATA_ACK: begin
                    if (ack_done) begin
                        ptr_d   = ptr_q + 8'd1;
                        state_d = ST_WDATA;
                    end
                end
                ST_RDATA: begin
                    if (scl_rise) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            state_d = ST_RDATA_ACK;
                        end
                    end
                    if (scl_fall) begin
                        sda_out_d = tx_q[7];
                        tx_d      = {tx_q[6:0], 1'b0};
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_fall) begin
                        if (!ninth_q) begin
                            sda_out_d = SDA_NACK;   // master owns the ACK slot
                        end else begin
                            ninth_d   = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_RDATA;
                            sda_out_d = tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                        end
                    end
                    if (scl_rise) begin
                        if (sda == SDA_ACK) begin
                            ninth_d   = 1'b1;
                            ptr_d     = ptr_q + 8'd1;
                            rd_req_d  = 1'b1;
                            rd_addr_d = ptr_q + 8'd1;
                        end else begin
                            state_d = ST_IGNORE;
                        end
                    end
                end
                default: begin
                    // IDLE and IGNORE wait for START/STOP with SDA released.
                    sda_out_d = SDA_NACK;
                end
            endcase
        end
    end

    assign o_sda         = sda_out_q;
    assign o_busy        = busy_q;
    assign o_reg_rd_req  = rd_req_q;
    assign o_reg_rd_addr = rd_addr_q;
    assign o_reg_wr_vld  = wr_vld_q;
    assign o_reg_wr_addr = wr_addr_q;
    assign o_reg_wr_data = wr_data_q;

endmodule

// File: tb/tb_wasm_i2c_dbg_slave.sv
// Self-checking bench for wasm_i2c_dbg_slave: a bit-banged I2C master, a
// register-file responder on the core side, and a transaction-level model
// (pointer + register image) that predicts every strobe and read byte.
module tb_wasm_i2c_dbg_slave;

    localparam int Q = 8;   // quarter SCL period in clk cycles (SCL = clk/32)

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       m_scl = 1'b1;
    logic       m_sda = 1'b1;
    logic       i_enable = 1'b1;
    logic       sda_line;
    logic       o_sda;
    logic       o_reg_rd_req;
    logic [7:0] o_reg_rd_addr;
    logic [7:0] i_reg_rd_data = 8'h00;
    logic       o_reg_wr_vld;
    logic [7:0] o_reg_wr_addr;
    logic [7:0] o_reg_wr_data;
    logic       o_busy;

    int checks = 0;
    int errors = 0;

    // core-side register file (served to the DUT) and the bench's model image
    logic [7:0]  core_mem  [256];
    logic [7:0]  model_mem [256];
    logic [7:0]  exp_ptr;
    logic [7:0]  rd_q [$];
    logic [15:0] wr_q [$];
    int          sda_low_cnt = 0;

    assign sda_line = m_sda & o_sda;

    always #5 clk = ~clk;

    wasm_i2c_dbg_slave dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_scl         (m_scl),
        .i_sda         (sda_line),
        .o_sda         (o_sda),
        .i_enable      (i_enable),
        .o_reg_rd_req  (o_reg_rd_req),
        .o_reg_rd_addr (o_reg_rd_addr),
        .i_reg_rd_data (i_reg_rd_data),
        .o_reg_wr_vld  (o_reg_wr_vld),
        .o_reg_wr_addr (o_reg_wr_addr),
        .o_reg_wr_data (o_reg_wr_data),
        .o_busy        (o_busy)
    );

    always @(posedge clk) begin
        if (o_reg_rd_req) begin
            i_reg_rd_data <= core_mem[o_reg_rd_addr];
            rd_q.push_back(o_reg_rd_addr);
        end
        if (o_reg_wr_vld) begin
            core_mem[o_reg_wr_addr] = o_reg_wr_data;
            wr_q.push_back({o_reg_wr_addr, o_reg_wr_data});
        end
        if (!o_sda) sda_low_cnt++;
    end

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- bus master primitives ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_bit(input logic b, output logic r);
        wait_clk(Q); m_sda = b;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(Q); r = sda_line;
        wait_clk(Q); m_scl = 1'b0;
    endtask

    task automatic bus_start();
        m_sda = 1'b1;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(Q); m_sda = 1'b0;
        wait_clk(Q); m_scl = 1'b0;
    endtask

    task automatic bus_stop();
        wait_clk(Q); m_sda = 1'b0;
        wait_clk(Q); m_scl = 1'b1;
        wait_clk(Q); m_sda = 1'b1;
        wait_clk(Q);
    endtask

    task automatic write_byte(input logic [7:0] d, output logic ack);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
        bus_bit(1'b1, ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] d);
        logic r;
        for (int i = 7; i >= 0; i--) bus_bit(1'b1, d[i]);
        bus_bit(nack, r);
    endtask

    task automatic clear_logs();
        rd_q.delete();
        wr_q.delete();
        sda_low_cnt = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        wait_clk(3);
        checks++; if (o_sda !== 1'b1) begin errors++; $display("FAIL reset_o_sda: got %b want 1", o_sda); end
        checks++; if (o_reg_rd_req !== 1'b0) begin errors++; $display("FAIL reset_rd_req: got %b want 0", o_reg_rd_req); end
        checks++; if (o_reg_wr_vld !== 1'b0) begin errors++; $display("FAIL reset_wr_vld: got %b want 0", o_reg_wr_vld); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_reg_rd_addr !== 8'h00) begin errors++; $display("FAIL reset_rd_addr: got %h want 00", o_reg_rd_addr); end
        checks++; if ({o_reg_wr_addr, o_reg_wr_data} !== 16'h0000) begin errors++; $display("FAIL reset_wr_bus: got %h want 0000", {o_reg_wr_addr, o_reg_wr_data}); end
        rst_n = 1'b1;
        wait_clk(5);
        checks++; if (o_sda !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: got sda=%b busy=%b want 1/0", o_sda, o_busy); end
        exp_ptr = 8'h00;
    endtask

    task automatic test_write_read_a5();
        logic a0, a1, a2;
        logic [7:0] d;
        clear_logs();
        bus_start(); write_byte(8'hD8, a0); write_byte(8'h02, a1); exp_ptr = 8'h02;
        bus_start(); write_byte(8'hD9, a2);
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL a5_busy: got %b want 1", o_busy); end
        read_byte(1'b1, d);
        bus_stop(); wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL a5_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL a5_rd_count: got %0d want 1", rd_q.size()); end
        else if (rd_q[0] !== 8'h02) begin errors++; $display("FAIL a5_rd_addr: got %h want 02", rd_q[0]); end
        checks++; if (d !== model_mem[8'h02]) begin errors++; $display("FAIL a5_data: got %h want %h", d, model_mem[8'h02]); end
        checks++; if (o_sda !== 1'b1 || o_busy !== 1'b0) begin errors++; $display("FAIL a5_after_stop: got sda=%b busy=%b want 1/0", o_sda, o_busy); end
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL a5_no_writes: got %0d want 0", wr_q.size()); end
    endtask

    task automatic test_pointer_wrap();
        logic a0, a1, a2;
        logic [7:0] d;
        logic [7:0] want;
        clear_logs();
        bus_start(); write_byte(8'hD8, a0); write_byte(8'hFE, a1); exp_ptr = 8'hFE;
        bus_start(); write_byte(8'hD9, a2);
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL wrap_acks: got %b want 000", {a0, a1, a2}); end
        for (int i = 0; i < 4; i++) begin
            want = model_mem[exp_ptr];
            read_byte(i == 3, d);
            checks++; if (d !== want) begin errors++; $display("FAIL wrap_data[%0d]: got %h want %h", i, d, want); end
            if (i != 3) exp_ptr = exp_ptr + 8'd1;
        end
        bus_stop(); wait_clk(4);
        checks++; if (rd_q.size() != 4) begin errors++; $display("FAIL wrap_rd_count: got %0d want 4", rd_q.size()); end
        else begin
            for (int i = 0; i < 4; i++) begin
                want = 8'hFE + 8'(i);
                checks++; if (rd_q[i] !== want) begin errors++; $display("FAIL wrap_rd_addr[%0d]: got %h want %h", i, rd_q[i], want); end
            end
        end
    endtask

    task automatic test_bad_address();
        logic a0, a1, a2;
        logic [6:0] other;
        clear_logs();
        bus_start(); write_byte({7'h50, 1'b0}, a0);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bad_busy: got %b want 0", o_busy); end
        write_byte(8'($urandom), a1);
        bus_stop();
        do other = 7'($urandom); while (other == 7'h6C);
        bus_start(); write_byte({other, 1'($urandom)}, a2);
        bus_stop(); wait_clk(4);
        checks++; if ({a0, a1, a2} !== 3'b111) begin errors++; $display("FAIL bad_nacks: got %b want 111 (addr %h)", {a0, a1, a2}, other); end
        checks++; if (sda_low_cnt != 0) begin errors++; $display("FAIL bad_sda_low: got %0d cycles want 0", sda_low_cnt); end
        checks++; if (rd_q.size() + wr_q.size() != 0) begin errors++; $display("FAIL bad_strobes: got %0d want 0", rd_q.size() + wr_q.size()); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL bad_busy_end: got %b want 0", o_busy); end
    endtask

    task automatic test_write_two();
        logic [3:0] acks;
        clear_logs();
        bus_start();
        write_byte(8'hD8, acks[3]); write_byte(8'h10, acks[2]);
        write_byte(8'h11, acks[1]); write_byte(8'h22, acks[0]);
        bus_stop(); wait_clk(4);
        model_mem[8'h10] = 8'h11; model_mem[8'h11] = 8'h22; exp_ptr = 8'h12;
        checks++; if (acks !== 4'b0000) begin errors++; $display("FAIL wr2_acks: got %b want 0000", acks); end
        checks++; if (wr_q.size() != 2) begin errors++; $display("FAIL wr2_count: got %0d want 2", wr_q.size()); end
        else begin
            checks++; if (wr_q[0] !== 16'h1011) begin errors++; $display("FAIL wr2_first: got %h want 1011", wr_q[0]); end
            checks++; if (wr_q[1] !== 16'h1122) begin errors++; $display("FAIL wr2_second: got %h want 1122", wr_q[1]); end
        end
    endtask

    task automatic test_stop_mid_byte();
        logic a0, a1, a2, r;
        logic [7:0] v;
        clear_logs();
        bus_start(); write_byte(8'hD8, a0); write_byte(8'h30, a1); exp_ptr = 8'h30;
        v = 8'($urandom);
        for (int i = 7; i >= 4; i--) bus_bit(v[i], r);
        bus_stop(); wait_clk(4);
        checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL midstop_no_write: got %0d want 0", wr_q.size()); end
        checks++; if (o_busy !== 1'b0 || o_sda !== 1'b1) begin errors++; $display("FAIL midstop_idle: got busy=%b sda=%b want 0/1", o_busy, o_sda); end
        v = 8'($urandom);
        bus_start(); write_byte(8'hD8, a0); write_byte(8'h31, a1); write_byte(v, a2);
        bus_stop(); wait_clk(4);
        model_mem[8'h31] = v; exp_ptr = 8'h32;
        checks++; if ({a0, a1, a2} !== 3'b000) begin errors++; $display("FAIL midstop_next_acks: got %b want 000", {a0, a1, a2}); end
        checks++; if (wr_q.size() != 1) begin errors++; $display("FAIL midstop_next_count: got %0d want 1", wr_q.size()); end
        else if (wr_q[0] !== {8'h31, v}) begin errors++; $display("FAIL midstop_next_write: got %h want %h", wr_q[0], {8'h31, v}); end
    endtask

    task automatic test_back_to_back();
        logic       ack;
        logic [7:0] p, d, want;
        logic [7:0] vals [4];
        int         n, nacks;
        for (int it = 0; it < 3; it++) begin
            clear_logs();
            p = 8'($urandom);
            n = $urandom_range(1, 4);
            nacks = 0;
            bus_start(); write_byte(8'hD8, ack); nacks += ack; write_byte(p, ack); nacks += ack;
            for (int i = 0; i < n; i++) begin
                vals[i] = 8'($urandom);
                write_byte(vals[i], ack); nacks += ack;
                model_mem[p + 8'(i)] = vals[i];
            end
            bus_start(); write_byte(8'hD8, ack); nacks += ack; write_byte(p, ack); nacks += ack;
            bus_start(); write_byte(8'hD9, ack); nacks += ack;
            exp_ptr = p;
            for (int i = 0; i < n; i++) begin
                want = model_mem[exp_ptr];
                read_byte(i == n - 1, d);
                checks++; if (d !== want) begin errors++; $display("FAIL b2b_data[%0d.%0d]: got %h want %h", it, i, d, want); end
                if (i != n - 1) exp_ptr = exp_ptr + 8'd1;
            end
            bus_stop(); wait_clk(4);
            checks++; if (nacks != 0) begin errors++; $display("FAIL b2b_acks[%0d]: got %0d nacks want 0", it, nacks); end
            checks++; if (wr_q.size() != n || rd_q.size() != n) begin errors++; $display("FAIL b2b_counts[%0d]: got wr=%0d rd=%0d want %0d", it, wr_q.size(), rd_q.size(), n); end
            else begin
                for (int i = 0; i < n; i++) begin
                    checks++; if (wr_q[i] !== {p + 8'(i), vals[i]} || rd_q[i] !== p + 8'(i)) begin
                        errors++; $display("FAIL b2b_strobe[%0d.%0d]: got wr=%h rd=%h want wr=%h rd=%h", it, i, wr_q[i], rd_q[i], {p + 8'(i), vals[i]}, p + 8'(i));
                    end
                end
            end
        end
    endtask

    task automatic test_reset_mid_ack();
        logic       r;
        logic [7:0] addr_byte, d;
        clear_logs();
        addr_byte = 8'hD9;
        bus_start();
        for (int i = 7; i >= 0; i--) bus_bit(addr_byte[i], r);
        wait_clk(6);
        checks++; if (o_sda !== 1'b0) begin errors++; $display("FAIL rst_pre_ack: got %b want 0", o_sda); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (o_sda !== 1'b1) begin errors++; $display("FAIL rst_async_release: got %b want 1", o_sda); end
        m_scl = 1'b1; m_sda = 1'b1;
        wait_clk(4); rst_n = 1'b1; wait_clk(4);
        exp_ptr = 8'h00;
        clear_logs();
        bus_start(); write_byte(8'hD9, r); read_byte(1'b1, d); bus_stop(); wait_clk(4);
        checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL rst_ptr_count: got %0d want 1", rd_q.size()); end
        else if (rd_q[0] !== exp_ptr) begin errors++; $display("FAIL rst_ptr_zero: got %h want %h", rd_q[0], exp_ptr); end
        checks++; if (d !== model_mem[exp_ptr]) begin errors++; $display("FAIL rst_read_data: got %h want %h", d, model_mem[exp_ptr]); end
    endtask

    task automatic test_enable_drop();
        logic       a, r;
        logic [7:0] d;
        int         nrd, nwr;
        clear_logs();
        bus_start(); write_byte(8'hD8, a); write_byte(8'h40, a); write_byte(8'h00, a);
        bus_stop();
        model_mem[8'h40] = 8'h00;
        bus_start(); write_byte(8'hD8, a); write_byte(8'h40, a);
        bus_start(); write_byte(8'hD9, a);
        exp_ptr = 8'h40;
        for (int i = 0; i < 3; i++) bus_bit(1'b1, r);
        wait_clk(6);
        checks++; if (o_sda !== 1'b0) begin errors++; $display("FAIL en_pre_drive: got %b want 0", o_sda); end
        i_enable = 1'b0;
        @(posedge clk); #1;
        checks++; if (o_sda !== 1'b1) begin errors++; $display("FAIL en_release: got %b want 1", o_sda); end
        nrd = rd_q.size(); nwr = wr_q.size(); sda_low_cnt = 0;
        for (int i = 0; i < 5; i++) bus_bit(1'b1, r);
        bus_bit(1'b0, r);
        read_byte(1'b1, d);
        bus_stop(); wait_clk(4);
        checks++; if (rd_q.size() != nrd || wr_q.size() != nwr) begin errors++; $display("FAIL en_no_strobes: got rd=%0d wr=%0d want %0d/%0d", rd_q.size(), wr_q.size(), nrd, nwr); end
        checks++; if (sda_low_cnt != 0 || o_busy !== 1'b0) begin errors++; $display("FAIL en_silent: got low=%0d busy=%b want 0/0", sda_low_cnt, o_busy); end
        i_enable = 1'b1; wait_clk(4);
        clear_logs();
        bus_start(); write_byte(8'hD9, a); read_byte(1'b1, d); bus_stop(); wait_clk(4);
        checks++; if (a !== 1'b0 || d !== model_mem[exp_ptr]) begin errors++; $display("FAIL en_resume: got ack=%b data=%h want 0/%h", a, d, model_mem[exp_ptr]); end
        checks++; if (rd_q.size() != 1) begin errors++; $display("FAIL en_resume_count: got %0d want 1", rd_q.size()); end
        else if (rd_q[0] !== exp_ptr) begin errors++; $display("FAIL en_resume_addr: got %h want %h", rd_q[0], exp_ptr); end
    endtask

    initial begin
        logic [7:0] v;
        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            core_mem[i]  = v;
            model_mem[i] = v;
        end
        core_mem[2]  = 8'hA5;
        model_mem[2] = 8'hA5;
        exp_ptr = 8'h00;

        test_reset();
        test_write_read_a5();
        test_pointer_wrap();
        test_bad_address();
        test_write_two();
        test_stop_mid_byte();
        test_back_to_back();
        test_reset_mid_ack();
        test_enable_drop();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
